kdtree_stream_loader: RTL and testbench
=======================================

KDTREE_STREAM_LOADER -- requirements
Module: kdtree_stream_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 11: width of one input word and each patch element.
REQ-002 Parameter PATCH_SIZE, default 5: data words per patch.
REQ-003 Parameter LEAF_SIZE, default 8: patches per leaf.
REQ-004 Parameter NUM_LEAVES, default 64: leaves; NUM_NODES = NUM_LEAVES-1 (derived).
REQ-005 Parameter NUM_QUERYS, default 494: query patches per frame.
REQ-006 wb_clk_i  in  1  sole clock; all logic on the rising edge.
REQ-007 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-008 load_kdtree  in  1  one-cycle command: start the node+leaf+query load sequence.
REQ-009 load_query  in  1  one-cycle command: reload queries only.
REQ-010 in_valid  in  1; in_data  in  DATA_WIDTH; in_ready  out  1  input word stream.
REQ-011 node_wen  out  1; node_waddr  out  clog2(NUM_NODES); node_widx, node_wmed  out  DATA_WIDTH each.
REQ-012 leaf_wen  out  1; leaf_waddr  out  clog2(NUM_LEAVES); leaf_wpatch  out  clog2(LEAF_SIZE); leaf_wdata  out  PATCH_SIZE*DATA_WIDTH; leaf_wpidx  out  DATA_WIDTH.
REQ-013 query_wen  out  1; query_waddr  out  clog2(NUM_QUERYS); query_wdata  out  PATCH_SIZE*DATA_WIDTH.
REQ-014 kdtree_loaded, query_loaded, busy, overflow_err  out  1 each: status.

Function
REQ-015 States: IDLE, NODES, LEAVES, QUERY, LOADED.
REQ-016 Word accepted iff in_valid && in_ready; in_ready = 1 only in NODES/LEAVES/QUERY and only when no command is asserted that cycle.
REQ-017 load_kdtree from any state -> NODES; clears kdtree_loaded, query_loaded and all counters; a concurrent in_valid word is not accepted.
REQ-018 load_query from IDLE or LOADED with kdtree_loaded=1 -> QUERY; clears query_loaded and the query counters; otherwise ignored; load_kdtree wins if both are asserted.
REQ-019 NODES: words alternate index, median; on the median word, node_wen pulses the next cycle with node_waddr = node number (0..NUM_NODES-1), node_widx = held index, node_wmed = median.
REQ-020 NODES -> LEAVES after 2*NUM_NODES accepted words.
REQ-021 LEAVES: each patch = PATCH_SIZE data words then 1 patch-index word; word k lands in leaf_wdata bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-022 On the patch-index word, leaf_wen pulses the next cycle with leaf_wpatch = patch within leaf and leaf_waddr = leaf number; patch wraps LEAF_SIZE-1 -> 0 and increments leaf.
REQ-023 LEAVES -> QUERY after NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) words; kdtree_loaded set at the same edge.
REQ-024 QUERY: PATCH_SIZE words per patch, packed as in REQ-021; query_wen pulses the cycle after the last word, query_waddr = 0..NUM_QUERYS-1.
REQ-025 After NUM_QUERYS patches -> LOADED; query_loaded set at the same edge.
REQ-026 Write latency is exactly 1 cycle after the completing word; write data/addr are held until the next write; wen pulses are 1 cycle wide.
REQ-027 Gaps: in_valid low holds all counters; no timeout.
REQ-028 in_valid=1 while in_ready=0 in IDLE/LOADED sets overflow_err (sticky until reset or load_kdtree); in_valid during a command cycle does not set it.
REQ-029 busy = 1 in NODES, LEAVES, QUERY.

Reset
REQ-030 wb_rst_i=1 at an edge -> IDLE, all counters 0, all outputs 0 (including data/addr), regardless of state; it overrides commands asserted the same cycle.
REQ-031 Reset mid-load discards partial patches; no wen pulse is issued for them.

Verification (NUM_LEAVES=4, LEAF_SIZE=2, PATCH_SIZE=5, NUM_QUERYS=6)
REQ-032 load_kdtree, then words 7,100,3,50,9,200 -> node_wen x3: (addr0,7,100),(1,3,50),(2,9,200); state LEAVES after word 6.
REQ-033 48 leaf words 1..5 then 11, repeated -> 8 leaf_wen pulses, (leaf,patch) = (0,0),(0,1),(1,0)...(3,1), leaf_wdata = {5,4,3,2,1}, leaf_wpidx=11; kdtree_loaded=1.
REQ-034 30 query words with random in_valid gaps -> 6 query_wen pulses at addr 0..5, each one cycle after its 5th word; query_loaded=1, busy=0.
REQ-035 In LOADED, load_query and in_valid in the same cycle -> word not accepted, overflow_err stays 0, query_waddr restarts at 0.
REQ-036 wb_rst_i asserted after 3 leaf words, then load_kdtree -> no leaf_wen, node_waddr restarts at 0.
REQ-037 in_valid in IDLE -> overflow_err=1 at the next cycle; cleared by load_kdtree.

Source files
------------

// File: rtl/kdtree_stream_loader.sv
// Streams a k-d tree image (node index/median pairs, leaf patches with patch
// indices, then query patches) from a word stream into node/leaf/query write ports.
module kdtree_stream_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494,
  localparam int NUM_NODES = NUM_LEAVES - 1,
  localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
  localparam int LW = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1,
  localparam int PW = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1,
  localparam int QW = (NUM_QUERYS > 1) ? $clog2(NUM_QUERYS) : 1,
  localparam int BW = PATCH_SIZE * DATA_WIDTH
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  load_kdtree,
  input  logic                  load_query,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  node_wen,
  output logic [NW-1:0]         node_waddr,
  output logic [DATA_WIDTH-1:0] node_widx,
  output logic [DATA_WIDTH-1:0] node_wmed,
  output logic                  leaf_wen,
  output logic [LW-1:0]         leaf_waddr,
  output logic [PW-1:0]         leaf_wpatch,
  output logic [BW-1:0]         leaf_wdata,
  output logic [DATA_WIDTH-1:0] leaf_wpidx,
  output logic                  query_wen,
  output logic [QW-1:0]         query_waddr,
  output logic [BW-1:0]         query_wdata,
  output logic                  kdtree_loaded,
  output logic                  query_loaded,
  output logic                  busy,
  output logic                  overflow_err
);

  localparam int WW = $clog2(PATCH_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NODES  = 3'd1,
    LEAVES = 3'd2,
    QUERY  = 3'd3,
    LOADED = 3'd4
  } state_t;

  state_t                state;
  logic                  node_phase;
  logic [NW-1:0]         node_cnt;
  logic [DATA_WIDTH-1:0] held_idx;
  logic [WW-1:0]         word_cnt;
  logic [PW-1:0]         patch_cnt;
  logic [LW-1:0]         leaf_cnt;
  logic [QW-1:0]         query_cnt;
  logic [BW-1:0]         patch_buf;
  logic [BW-1:0]         buf_next;
  logic                  accept;
  logic                  streaming;

  assign streaming = (state == NODES) || (state == LEAVES) || (state == QUERY);
  assign in_ready  = streaming && !load_kdtree && !load_query;
  assign busy      = streaming;
  assign accept    = in_valid && in_ready;

  // Patch buffer with the current word dropped into its slot; the index word leaves it unchanged
  always_comb begin
    buf_next = patch_buf;
    if (word_cnt < WW'(PATCH_SIZE)) begin
      buf_next[int'(word_cnt) * DATA_WIDTH +: DATA_WIDTH] = in_data;
    end else begin
      buf_next = patch_buf;
    end
  end

  // Load sequencer: commands, word routing, write pulses and status flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      node_phase    <= 1'b0;
      node_cnt      <= '0;
      held_idx      <= '0;
      word_cnt      <= '0;
      patch_cnt     <= '0;
      leaf_cnt      <= '0;
      query_cnt     <= '0;
      patch_buf     <= '0;
      node_wen      <= 1'b0;
      node_waddr    <= '0;
      node_widx     <= '0;
      node_wmed     <= '0;
      leaf_wen      <= 1'b0;
      leaf_waddr    <= '0;
      leaf_wpatch   <= '0;
      leaf_wdata    <= '0;
      leaf_wpidx    <= '0;
      query_wen     <= 1'b0;
      query_waddr   <= '0;
      query_wdata   <= '0;
      kdtree_loaded <= 1'b0;
      query_loaded  <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;
      query_wen <= 1'b0;
      if (load_kdtree) begin
        state         <= NODES;
        node_phase    <= 1'b0;
        node_cnt      <= '0;
        word_cnt      <= '0;
        patch_cnt     <= '0;
        leaf_cnt      <= '0;
        query_cnt     <= '0;
        kdtree_loaded <= 1'b0;
        query_loaded  <= 1'b0;
        overflow_err  <= 1'b0;
      end else if (load_query && kdtree_loaded && ((state == IDLE) || (state == LOADED))) begin
        state        <= QUERY;
        word_cnt     <= '0;
        query_cnt    <= '0;
        query_loaded <= 1'b0;
      end else begin
        // Words offered while nothing is loading are lost; command cycles are exempt
        if (in_valid && !in_ready && !load_query && ((state == IDLE) || (state == LOADED))) begin
          overflow_err <= 1'b1;
        end
        if (accept) begin
          case (state)
            NODES: begin
              if (!node_phase) begin
                held_idx   <= in_data;
                node_phase <= 1'b1;
              end else begin
                node_phase <= 1'b0;
                node_wen   <= 1'b1;
                node_waddr <= node_cnt;
                node_widx  <= held_idx;
                node_wmed  <= in_data;
                if (node_cnt == NW'(NUM_NODES - 1)) begin
                  node_cnt <= '0;
                  state    <= LEAVES;
                end else begin
                  node_cnt <= node_cnt + 1'b1;
                end
              end
            end
            LEAVES: begin
              if (word_cnt != WW'(PATCH_SIZE)) begin
                patch_buf <= buf_next;
                word_cnt  <= word_cnt + 1'b1;
              end else begin
                word_cnt    <= '0;
                leaf_wen    <= 1'b1;
                leaf_wdata  <= patch_buf;
                leaf_wpidx  <= in_data;
                leaf_waddr  <= leaf_cnt;
                leaf_wpatch <= patch_cnt;
                if (patch_cnt == PW'(LEAF_SIZE - 1)) begin
                  patch_cnt <= '0;
                  if (leaf_cnt == LW'(NUM_LEAVES - 1)) begin
                    leaf_cnt      <= '0;
                    state         <= QUERY;
                    kdtree_loaded <= 1'b1;
                  end else begin
                    leaf_cnt <= leaf_cnt + 1'b1;
                  end
                end else begin
                  patch_cnt <= patch_cnt + 1'b1;
                end
              end
            end
            QUERY: begin
              patch_buf <= buf_next;
              if (word_cnt == WW'(PATCH_SIZE - 1)) begin
                word_cnt    <= '0;
                query_wen   <= 1'b1;
                query_wdata <= buf_next;
                query_waddr <= query_cnt;
                if (query_cnt == QW'(NUM_QUERYS - 1)) begin
                  query_cnt    <= '0;
                  state        <= LOADED;
                  query_loaded <= 1'b1;
                end else begin
                  query_cnt <= query_cnt + 1'b1;
                end
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_kdtree_stream_loader.sv
// Self-checking bench for kdtree_stream_loader: directed tables, corner sequences
// and a randomized full load checked against a word-number based reference model.
module tb_kdtree_stream_loader;

  localparam int DW = 11;
  localparam int PS = 5;
  localparam int LS = 2;
  localparam int NL = 4;
  localparam int NQ = 6;
  localparam int NN = NL - 1;
  localparam int NODE_WORDS = 2 * NN;
  localparam int LEAF_WORDS = NL * LS * (PS + 1);
  localparam int Q_START    = NODE_WORDS + LEAF_WORDS;
  localparam int TOTAL      = Q_START + NQ * PS;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_kdtree;
  logic             load_query;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             node_wen;
  logic [1:0]       node_waddr;
  logic [DW-1:0]    node_widx;
  logic [DW-1:0]    node_wmed;
  logic             leaf_wen;
  logic [1:0]       leaf_waddr;
  logic [0:0]       leaf_wpatch;
  logic [PS*DW-1:0] leaf_wdata;
  logic [DW-1:0]    leaf_wpidx;
  logic             query_wen;
  logic [2:0]       query_waddr;
  logic [PS*DW-1:0] query_wdata;
  logic             kdtree_loaded;
  logic             query_loaded;
  logic             busy;
  logic             overflow_err;

  kdtree_stream_loader #(
    .DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS), .NUM_LEAVES(NL), .NUM_QUERYS(NQ)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .load_kdtree(load_kdtree), .load_query(load_query),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .node_wen(node_wen), .node_waddr(node_waddr), .node_widx(node_widx), .node_wmed(node_wmed),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wpatch(leaf_wpatch),
    .leaf_wdata(leaf_wdata), .leaf_wpidx(leaf_wpidx),
    .query_wen(query_wen), .query_waddr(query_waddr), .query_wdata(query_wdata),
    .kdtree_loaded(kdtree_loaded), .query_loaded(query_loaded), .busy(busy),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] hist [0:TOTAL-1];
  int wn = 0;

  typedef struct {
    logic [DW-1:0] idx;
    logic [DW-1:0] med;
    logic [1:0]    addr;
  } node_vec_t;
  node_vec_t nv [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Patch image: word k of the patch in bits [k*DW +: DW]
  function automatic logic [PS*DW-1:0] pack(input int base);
    logic [PS*DW-1:0] v;
    v = '0;
    for (int k = 0; k < PS; k++) v[k*DW +: DW] = hist[base + k];
    return v;
  endfunction

  // Offer one word; the model decides from its position in the load which write it completes
  task automatic send(input logic [DW-1:0] w);
    logic enw, elw, eqw;
    int m, j, q;
    in_data = w;
    in_valid = 1'b1;
    #1;
    chk("in_ready", 64'(in_ready), 64'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    hist[wn] = w;
    enw = 1'b0; elw = 1'b0; eqw = 1'b0;
    if (wn < NODE_WORDS) begin
      if (wn % 2 == 1) begin
        enw = 1'b1;
        chk("node_waddr", 64'(node_waddr), 64'(wn / 2));
        chk("node_widx", 64'(node_widx), 64'(hist[wn-1]));
        chk("node_wmed", 64'(node_wmed), 64'(w));
      end
    end else if (wn < Q_START) begin
      m = wn - NODE_WORDS;
      if (m % (PS + 1) == PS) begin
        elw = 1'b1;
        j = m / (PS + 1);
        chk("leaf_waddr", 64'(leaf_waddr), 64'(j / LS));
        chk("leaf_wpatch", 64'(leaf_wpatch), 64'(j % LS));
        chk("leaf_wdata", 64'(leaf_wdata), 64'(pack(NODE_WORDS + j * (PS + 1))));
        chk("leaf_wpidx", 64'(leaf_wpidx), 64'(w));
      end
    end else begin
      q = wn - Q_START;
      if (q % PS == PS - 1) begin
        eqw = 1'b1;
        chk("query_waddr", 64'(query_waddr), 64'(q / PS));
        chk("query_wdata", 64'(query_wdata), 64'(pack(Q_START + (q / PS) * PS)));
      end
    end
    chk("node_wen", 64'(node_wen), 64'(enw));
    chk("leaf_wen", 64'(leaf_wen), 64'(elw));
    chk("query_wen", 64'(query_wen), 64'(eqw));
    wn++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("no_wen", 64'({node_wen, leaf_wen, query_wen}), 64'(3'b000));
    end
  endtask

  task automatic command(input logic kd, input logic lq, input logic v, input logic [DW-1:0] w);
    load_kdtree = kd;
    load_query = lq;
    in_valid = v;
    in_data = w;
    #1;
    chk("ready_in_cmd", 64'(in_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    load_kdtree = 1'b0;
    load_query = 1'b0;
    in_valid = 1'b0;
    if (kd) wn = 0;
    else if (lq) wn = Q_START;
  endtask

  initial begin
    logic [PS*DW-1:0] leaf_exp;
    leaf_exp = {11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    nv[0] = '{11'd7, 11'd100, 2'd0};
    nv[1] = '{11'd3, 11'd50,  2'd1};
    nv[2] = '{11'd9, 11'd200, 2'd2};

    rst = 1'b1; load_kdtree = 1'b0; load_query = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_ready", 64'(in_ready), 64'(1'b0));
    chk("rst_loaded", 64'({kdtree_loaded, query_loaded, overflow_err}), 64'(3'b000));
    chk("rst_wen", 64'({node_wen, leaf_wen, query_wen}), 64'(3'b000));
    chk("rst_leaf_wdata", 64'(leaf_wdata), 64'(0));

    // Word offered in IDLE: lost and flagged, flag is sticky until load_kdtree
    in_valid = 1'b1; in_data = 11'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ovf_set", 64'(overflow_err), 64'(1'b1));
    idle(2);
    chk("ovf_sticky", 64'(overflow_err), 64'(1'b1));
    command(1'b1, 1'b0, 1'b0, 11'd0);
    chk("ovf_clear", 64'(overflow_err), 64'(1'b0));
    chk("busy_nodes", 64'(busy), 64'(1'b1));

    // Node table
    for (int i = 0; i < 3; i++) begin
      send(nv[i].idx);
      send(nv[i].med);
      chk("tbl_node_addr", 64'(node_waddr), 64'(nv[i].addr));
      chk("tbl_node_idx", 64'(node_widx), 64'(nv[i].idx));
      chk("tbl_node_med", 64'(node_wmed), 64'(nv[i].med));
    end
    chk("kd_not_yet", 64'(kdtree_loaded), 64'(1'b0));

    // Leaf patches 1..5 + index 11
    for (int j = 0; j < NL * LS; j++) begin
      for (int k = 1; k <= PS; k++) send(DW'(k));
      send(11'd11);
      chk("leaf_pos", 64'({leaf_waddr, leaf_wpatch}), 64'(j));
      chk("leaf_const", 64'(leaf_wdata), 64'(leaf_exp));
    end
    chk("kd_loaded", 64'(kdtree_loaded), 64'(1'b1));
    chk("q_not_yet", 64'(query_loaded), 64'(1'b0));

    // Queries with random gaps
    for (int i = 0; i < NQ * PS; i++) begin
      idle($urandom_range(0, 2));
      send(DW'($urandom_range(0, 2047)));
    end
    chk("q_loaded", 64'(query_loaded), 64'(1'b1));
    chk("idle_busy", 64'(busy), 64'(1'b0));
    idle(2);
    chk("q_addr_held", 64'(query_waddr), 64'(5));

    // load_query with a concurrent word in LOADED
    command(1'b0, 1'b1, 1'b1, 11'd77);
    chk("lq_no_ovf", 64'(overflow_err), 64'(1'b0));
    chk("lq_busy", 64'(busy), 64'(1'b1));
    chk("lq_clear", 64'(query_loaded), 64'(1'b0));
    for (int i = 0; i < PS; i++) send(DW'($urandom_range(0, 2047)));
    chk("lq_addr0", 64'(query_waddr), 64'(0));

    // Reset mid-leaf (with a colliding load_kdtree) discards the partial patch
    command(1'b1, 1'b0, 1'b0, 11'd0);
    for (int i = 0; i < NODE_WORDS + 3; i++) send(DW'($urandom_range(0, 2047)));
    rst = 1'b1; load_kdtree = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; load_kdtree = 1'b0;
    chk("rst_override", 64'(busy), 64'(1'b0));
    chk("rst_node_idx", 64'(node_widx), 64'(0));
    chk("rst_node_addr", 64'(node_waddr), 64'(0));
    chk("rst_kd", 64'(kdtree_loaded), 64'(1'b0));
    idle(2);
    command(1'b1, 1'b0, 1'b0, 11'd0);
    idle(1);
    send(DW'($urandom_range(0, 2047)));
    send(DW'($urandom_range(0, 2047)));
    chk("restart_addr0", 64'(node_waddr), 64'(0));

    // Randomized full load from here against the model
    while (wn < TOTAL) begin
      idle($urandom_range(0, 1));
      send(DW'($urandom_range(0, 2047)));
    end
    chk("final_flags", 64'({kdtree_loaded, query_loaded, busy, overflow_err}), 64'(4'b1100));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ovf_loaded", 64'(overflow_err), 64'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
